// File: rtl/rob_param.sv
// rob_param: parametrised reorder buffer. Allocation is in order, completion is out of order, retirement is in order.
// Optional dual retirement is enabled by defining ROB_DUAL_COMMIT_EN.
module rob_param #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 4,
    parameter int REG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             rdy_i,
    input  logic             alloc_valid_i,
    input  logic [1:0]       alloc_kind_i,
    input  logic [REG_W-1:0] alloc_dest_i,
    output logic [TAG_W-1:0] alloc_tag_o,
    output logic             full_o,
    output logic [TAG_W:0]   count_o,
    input  logic             alu_valid_i,
    input  logic [TAG_W-1:0] alu_tag_i,
    input  logic [31:0]      alu_value_i,
    input  logic             alu_mispred_i,
    input  logic [31:0]      alu_target_i,
    input  logic             lad_valid_i,
    input  logic [TAG_W-1:0] lad_tag_i,
    input  logic [31:0]      lad_value_i,
    input  logic             str_valid_i,
    input  logic [TAG_W-1:0] str_tag_i,
    output logic             cm0_valid_o,
    output logic [REG_W-1:0] cm0_rd_o,
    output logic [31:0]      cm0_value_o,
    output logic             cm1_valid_o,
    output logic [REG_W-1:0] cm1_rd_o,
    output logic [31:0]      cm1_value_o,
    output logic             cm_store_o,
    output logic             redirect_valid_o,
    output logic [31:0]      redirect_pc_o
);
    localparam logic [1:0] KIND_REG  = 2'd0;
    localparam logic [1:0] KIND_STR  = 2'd1;
    localparam logic [1:0] KIND_BRA  = 2'd2;
    localparam logic [1:0] KIND_JALR = 2'd3;

    logic [TAG_W:0]     head_q, head_d, tail_q, tail_d, count_q, count_d;
    logic [DEPTH-1:0]   busy_q, busy_d, done_q, done_d;
    logic [DEPTH-1:0]   mispred_q;
    logic [1:0]         kind_q   [DEPTH];
    logic [REG_W-1:0]   dest_q   [DEPTH];
    logic [31:0]        value_q  [DEPTH];
    logic [31:0]        target_q [DEPTH];

    logic [TAG_W-1:0]   h0_idx, t_idx;
    logic [1:0]         h0_kind;
    logic               alloc_fire, alu_hit, lad_hit, str_hit;
    logic               commit0, commit1, cm0_we, st_fire, redirect;
    logic [1:0]         n_commit;

    logic               cm0_valid_q, cm_store_q, redirect_valid_q;
    logic [REG_W-1:0]   cm0_rd_q;
    logic [31:0]        cm0_value_q, redirect_pc_q;

    assign h0_idx      = head_q[TAG_W-1:0];
    assign t_idx       = tail_q[TAG_W-1:0];
    assign h0_kind     = kind_q[h0_idx];
    assign full_o      = (head_q[TAG_W] != tail_q[TAG_W]) && (h0_idx == t_idx);
    assign alloc_tag_o = t_idx;
    assign count_o     = count_q;

    assign alloc_fire = alloc_valid_i && !full_o;
    assign alu_hit    = alu_valid_i && busy_q[alu_tag_i];
    assign lad_hit    = lad_valid_i && busy_q[lad_tag_i];
    assign str_hit    = str_valid_i && busy_q[str_tag_i];

    assign commit0  = busy_q[h0_idx] && done_q[h0_idx];
    assign cm0_we   = commit0 && ((h0_kind == KIND_REG) || (h0_kind == KIND_JALR));
    assign st_fire  = commit0 && (h0_kind == KIND_STR);
    assign redirect = commit0 && mispred_q[h0_idx] &&
                      ((h0_kind == KIND_BRA) || (h0_kind == KIND_JALR));

`ifdef ROB_DUAL_COMMIT_EN
    logic [TAG_W-1:0] h1_idx;
    assign h1_idx  = h0_idx + TAG_W'(1);
    // Slot 1 only ever retires a REG, so at most one store leaves per cycle.
    assign commit1 = commit0 && ((h0_kind == KIND_REG) || (h0_kind == KIND_STR)) &&
                     busy_q[h1_idx] && done_q[h1_idx] && (kind_q[h1_idx] == KIND_REG);
`else
    assign commit1 = 1'b0;
`endif

    assign n_commit = {1'b0, commit0} + {1'b0, commit1};

    always_comb begin
        busy_d  = busy_q;
        done_d  = done_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirect) begin
            busy_d  = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (str_hit) done_d[str_tag_i] = 1'b1;
            if (lad_hit) done_d[lad_tag_i] = 1'b1;
            if (alu_hit) done_d[alu_tag_i] = 1'b1;
            if (commit0) busy_d[h0_idx] = 1'b0;
            if (commit1) busy_d[h0_idx + TAG_W'(1)] = 1'b0;
            if (alloc_fire) begin
                busy_d[t_idx] = 1'b1;
                done_d[t_idx] = 1'b0;
                tail_d        = tail_q + (TAG_W+1)'(1);
            end
            head_d  = head_q + (TAG_W+1)'(n_commit);
            count_d = count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(n_commit);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            busy_q           <= '0;
            done_q           <= '0;
            cm0_valid_q      <= 1'b0;
            cm0_rd_q         <= '0;
            cm0_value_q      <= '0;
            cm_store_q       <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else if (rdy_i) begin
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            cm0_valid_q      <= cm0_we;
            cm_store_q       <= st_fire;
            redirect_valid_q <= redirect;
            if (cm0_we) begin
                cm0_rd_q    <= dest_q[h0_idx];
                cm0_value_q <= value_q[h0_idx];
            end
            if (redirect) redirect_pc_q <= target_q[h0_idx];
        end
    end

    // Payload storage needs no reset: an entry is only read once busy, and allocation rewrites it.
    always_ff @(posedge clk_i) begin
        if (rdy_i && !redirect) begin
            if (lad_hit) value_q[lad_tag_i] <= lad_value_i;
            if (alu_hit) begin
                value_q[alu_tag_i]   <= alu_value_i;
                mispred_q[alu_tag_i] <= alu_mispred_i;
                target_q[alu_tag_i]  <= alu_target_i;
            end
            if (alloc_fire) begin
                kind_q[t_idx]    <= alloc_kind_i;
                dest_q[t_idx]    <= alloc_dest_i;
                mispred_q[t_idx] <= 1'b0;
            end
        end
    end

    assign cm0_valid_o      = cm0_valid_q;
    assign cm0_rd_o         = cm0_rd_q;
    assign cm0_value_o      = cm0_value_q;
    assign cm_store_o       = cm_store_q;
    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;

`ifdef ROB_DUAL_COMMIT_EN
    logic             cm1_valid_q;
    logic [REG_W-1:0] cm1_rd_q;
    logic [31:0]      cm1_value_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cm1_valid_q <= 1'b0;
            cm1_rd_q    <= '0;
            cm1_value_q <= '0;
        end else if (rdy_i) begin
            cm1_valid_q <= commit1;
            if (commit1) begin
                cm1_rd_q    <= dest_q[h1_idx];
                cm1_value_q <= value_q[h1_idx];
            end
        end
    end

    assign cm1_valid_o = cm1_valid_q;
    assign cm1_rd_o    = cm1_rd_q;
    assign cm1_value_o = cm1_value_q;
`else
    assign cm1_valid_o = 1'b0;
    assign cm1_rd_o    = '0;
    assign cm1_value_o = '0;
`endif

endmodule

// File: tb/tb_rob_param.sv
// Testbench for rob_param: directed scenarios plus randomized episodes, checked by a commit scoreboard.
`timescale 1ns/1ps
module tb_rob_param;
    localparam int DEPTH = 16;
    localparam int TAG_W = 4;
    localparam int REG_W = 5;
    localparam logic [1:0] KREG = 2'd0, KSTR = 2'd1, KBRA = 2'd2, KJALR = 2'd3;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             rdy_i = 1'b1;
    logic             alloc_valid_i = 1'b0;
    logic [1:0]       alloc_kind_i = '0;
    logic [REG_W-1:0] alloc_dest_i = '0;
    logic [TAG_W-1:0] alloc_tag_o;
    logic             full_o;
    logic [TAG_W:0]   count_o;
    logic             alu_valid_i = 1'b0;
    logic [TAG_W-1:0] alu_tag_i = '0;
    logic [31:0]      alu_value_i = '0;
    logic             alu_mispred_i = 1'b0;
    logic [31:0]      alu_target_i = '0;
    logic             lad_valid_i = 1'b0;
    logic [TAG_W-1:0] lad_tag_i = '0;
    logic [31:0]      lad_value_i = '0;
    logic             str_valid_i = 1'b0;
    logic [TAG_W-1:0] str_tag_i = '0;
    logic             cm0_valid_o, cm1_valid_o, cm_store_o, redirect_valid_o;
    logic [REG_W-1:0] cm0_rd_o, cm1_rd_o;
    logic [31:0]      cm0_value_o, cm1_value_o, redirect_pc_o;

    rob_param #(.DEPTH(DEPTH), .TAG_W(TAG_W), .REG_W(REG_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .rdy_i(rdy_i),
        .alloc_valid_i(alloc_valid_i), .alloc_kind_i(alloc_kind_i), .alloc_dest_i(alloc_dest_i),
        .alloc_tag_o(alloc_tag_o), .full_o(full_o), .count_o(count_o),
        .alu_valid_i(alu_valid_i), .alu_tag_i(alu_tag_i), .alu_value_i(alu_value_i),
        .alu_mispred_i(alu_mispred_i), .alu_target_i(alu_target_i),
        .lad_valid_i(lad_valid_i), .lad_tag_i(lad_tag_i), .lad_value_i(lad_value_i),
        .str_valid_i(str_valid_i), .str_tag_i(str_tag_i),
        .cm0_valid_o(cm0_valid_o), .cm0_rd_o(cm0_rd_o), .cm0_value_o(cm0_value_o),
        .cm1_valid_o(cm1_valid_o), .cm1_rd_o(cm1_rd_o), .cm1_value_o(cm1_value_o),
        .cm_store_o(cm_store_o), .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic             wr;
        logic [REG_W-1:0] rd;
        logic [31:0]      val;
        logic             st;
        logic             re;
        logic [31:0]      pc;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  m_tail = 0;
    logic en_edge = 1'b0;

    always @(posedge clk_i) en_edge <= rdy_i;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic push_ev(input logic wr, input logic [REG_W-1:0] rd, input logic [31:0] val,
                           input logic st, input logic re, input logic [31:0] pc);
        ev_t e;
        e.wr = wr; e.rd = rd; e.val = val; e.st = st; e.re = re; e.pc = pc;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input string nm, input logic wr, input logic [REG_W-1:0] rd,
                            input logic [31:0] val, input logic st, input logic re, input logic [31:0] pc);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: unexpected commit wr=%0b rd=%0d val=%h st=%0b re=%0b pc=%h, expected none",
                     nm, wr, rd, val, st, re, pc);
            return;
        end
        e = exp_q.pop_front();
        if (wr !== e.wr || st !== e.st || re !== e.re ||
            (e.wr && (rd !== e.rd || val !== e.val)) || (e.re && pc !== e.pc)) begin
            n_err++;
            $display("FAIL %s: got wr=%0b rd=%0d val=%h st=%0b re=%0b pc=%h expected wr=%0b rd=%0d val=%h st=%0b re=%0b pc=%h",
                     nm, wr, rd, val, st, re, pc, e.wr, e.rd, e.val, e.st, e.re, e.pc);
        end
    endtask

    // Each enabled edge retires at most one event per slot, oldest in slot 0.
    always @(negedge clk_i) begin
        if (rst_ni && en_edge) begin
            if (cm0_valid_o || cm_store_o || redirect_valid_o)
                check_ev("commit_slot0", cm0_valid_o, cm0_rd_o, cm0_value_o, cm_store_o,
                         redirect_valid_o, redirect_pc_o);
            if (cm1_valid_o)
                check_ev("commit_slot1", 1'b1, cm1_rd_o, cm1_value_o, 1'b0, 1'b0, 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic alloc(input logic [1:0] k, input logic [REG_W-1:0] d);
        rdy_i = 1'b1;
        alloc_valid_i = 1'b1; alloc_kind_i = k; alloc_dest_i = d;
        tick();
        alloc_valid_i = 1'b0;
    endtask

    // port: 0 = alu, 1 = load, 2 = store
    task automatic complete(input int port, input logic [TAG_W-1:0] tag, input logic [31:0] val,
                            input logic mis, input logic [31:0] tgt);
        rdy_i = 1'b1;
        case (port)
            0: begin alu_valid_i = 1'b1; alu_tag_i = tag; alu_value_i = val;
                     alu_mispred_i = mis; alu_target_i = tgt; end
            1: begin lad_valid_i = 1'b1; lad_tag_i = tag; lad_value_i = val; end
            default: begin str_valid_i = 1'b1; str_tag_i = tag; end
        endcase
        tick();
        alu_valid_i = 1'b0; lad_valid_i = 1'b0; str_valid_i = 1'b0;
    endtask

    task automatic stall();
        rdy_i = 1'b0;
        tick();
        rdy_i = 1'b1;
    endtask

    task automatic drain(input string nm);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 400) begin
            rdy_i = ($urandom_range(0, 4) != 0);
            tick();
            c++;
        end
        rdy_i = 1'b1;
        if (exp_q.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL %s: timeout with %0d commits outstanding, expected 0", nm, exp_q.size());
            exp_q.delete();
        end
        tick();
    endtask

    task automatic episode(input int ep);
        logic [1:0]       k [DEPTH];
        logic [REG_W-1:0] d [DEPTH];
        logic [31:0]      v [DEPTH];
        logic [31:0]      t [DEPTH];
        logic             m [DEPTH];
        int               ord [DEPTH];
        int               n, base, j, tmp;
        bit               flushed;
        n = $urandom_range(1, DEPTH);
        base = m_tail;
        flushed = 0;
        for (int i = 0; i < n; i++) begin
            k[i] = 2'($urandom_range(0, 3));
            d[i] = REG_W'($urandom_range(0, 31));
            v[i] = $urandom;
            t[i] = $urandom;
            m[i] = ($urandom_range(0, 6) == 0);
            ord[i] = i;
        end
        // Program-order reference: everything younger than the first mispredict is flushed.
        for (int i = 0; i < n && !flushed; i++) begin
            case (k[i])
                KREG:    push_ev(1'b1, d[i], v[i], 1'b0, 1'b0, 32'h0);
                KSTR:    push_ev(1'b0, '0, 32'h0, 1'b1, 1'b0, 32'h0);
                KBRA:    if (m[i]) push_ev(1'b0, '0, 32'h0, 1'b0, 1'b1, t[i]);
                default: push_ev(1'b1, d[i], v[i], 1'b0, m[i], t[i]);
            endcase
            if ((k[i] == KBRA || k[i] == KJALR) && m[i]) flushed = 1;
        end
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 4) == 0) stall();
            check($sformatf("ep%0d_alloc_tag%0d", ep, i), 64'(alloc_tag_o), 64'((base + i) % DEPTH));
            alloc(k[i], d[i]);
        end
        for (int i = n - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
        end
        for (int i = 0; i < n; i++) begin
            j = ord[i];
            if ($urandom_range(0, 4) == 0) stall();
            case (k[j])
                KREG:    complete($urandom_range(0, 1), TAG_W'(base + j), v[j], 1'($urandom_range(0, 1)), $urandom);
                KSTR:    complete(2, TAG_W'(base + j), 32'h0, 1'b0, 32'h0);
                default: complete(0, TAG_W'(base + j), v[j], m[j], t[j]);
            endcase
        end
        drain($sformatf("ep%0d_drain", ep));
        m_tail = flushed ? 0 : (base + n) % DEPTH;
        check($sformatf("ep%0d_count", ep), 64'(count_o), 64'(0));
        check($sformatf("ep%0d_tail", ep), 64'(alloc_tag_o), 64'(m_tail));
    endtask

    initial begin
        logic [REG_W-1:0] fd [DEPTH];
        logic [31:0]      fv [DEPTH];
        int  base;
        bit  found;

        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        check("reset_outputs", 64'({cm0_valid_o, cm1_valid_o, cm_store_o, redirect_valid_o, full_o, count_o}), 64'(0));
        check("reset_alloc_tag", 64'(alloc_tag_o), 64'(0));

        // Fill to full, reject one more, complete in reverse, retire in order.
        for (int i = 0; i < DEPTH; i++) begin
            fd[i] = REG_W'($urandom_range(1, 31));
            fv[i] = $urandom;
            alloc(KREG, fd[i]);
        end
        check("fill_count", 64'(count_o), 64'(16));
        check("fill_full", 64'(full_o), 64'(1));
        alloc(KREG, 5'd3);
        check("fill_17th_ignored", 64'(count_o), 64'(16));
        check("fill_tag_wrapped", 64'(alloc_tag_o), 64'(0));
        for (int i = 0; i < DEPTH; i++) push_ev(1'b1, fd[i], fv[i], 1'b0, 1'b0, 32'h0);
        for (int i = DEPTH - 1; i >= 0; i--) complete(i % 2, TAG_W'(i), fv[i], 1'b0, 32'h0);
        drain("fill_drain");
        check("fill_count_empty", 64'(count_o), 64'(0));
        check("wrap_alloc_tag", 64'(alloc_tag_o), 64'(0));
        alloc(KREG, 5'd4);
        push_ev(1'b1, 5'd4, 32'h4444, 1'b0, 1'b0, 32'h0);
        complete(1, 4'd0, 32'h4444, 1'b0, 32'h0);
        drain("wrap_drain");
        m_tail = 1;

        // Out-of-order completion.
        base = m_tail;
        alloc(KREG, 5'd1);
        alloc(KREG, 5'd2);
        push_ev(1'b1, 5'd1, 32'h11, 1'b0, 1'b0, 32'h0);
        push_ev(1'b1, 5'd2, 32'h22, 1'b0, 1'b0, 32'h0);
        complete(0, TAG_W'(base + 1), 32'h22, 1'b0, 32'h0);
        complete(1, TAG_W'(base), 32'h11, 1'b0, 32'h0);
        drain("ooo_drain");
        m_tail = base + 2;

        // JALR mispredict: link write and redirect together, then empty.
        base = m_tail;
        alloc(KJALR, 5'd1);
        alloc(KREG, 5'd3);
        alloc(KREG, 5'd4);
        alloc(KREG, 5'd5);
        push_ev(1'b1, 5'd1, 32'h104, 1'b0, 1'b1, 32'h200);
        complete(0, TAG_W'(base), 32'h104, 1'b1, 32'h200);
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk_i);
            if (redirect_valid_o) found = 1;
        end
        check("jalr_redirect_seen", 64'(found), 64'(1));
        check("jalr_count", 64'(count_o), 64'(0));
        check("jalr_alloc_tag", 64'(alloc_tag_o), 64'(0));
        drain("jalr_drain");
        m_tail = 0;

        // Load completion and allocation in the redirect cycle are both discarded.
        alloc(KBRA, 5'd0);
        alloc(KREG, 5'd7);
        push_ev(1'b0, '0, 32'h0, 1'b0, 1'b1, 32'h300);
        complete(0, 4'd0, 32'h0, 1'b1, 32'h300);
        lad_valid_i = 1'b1; lad_tag_i = 4'd1; lad_value_i = 32'h55;
        alloc_valid_i = 1'b1; alloc_kind_i = KREG; alloc_dest_i = 5'd9;
        tick();
        lad_valid_i = 1'b0; alloc_valid_i = 1'b0;
        check("coll_redirect", 64'(redirect_valid_o), 64'(1));
        check("coll_count", 64'(count_o), 64'(0));
        check("coll_alloc_tag", 64'(alloc_tag_o), 64'(0));
        drain("coll_drain");
        check("coll_count_after", 64'(count_o), 64'(0));
        m_tail = 0;

        // Hold with rdy low while the head is ready to retire.
        alloc(KREG, 5'd10);
        push_ev(1'b1, 5'd10, 32'hABCD, 1'b0, 1'b0, 32'h0);
        complete(0, 4'd0, 32'hABCD, 1'b0, 32'h0);
        rdy_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rdy_hold_count%0d", i), 64'(count_o), 64'(1));
            check($sformatf("rdy_hold_cm0_%0d", i), 64'(cm0_valid_o), 64'(0));
        end
        rdy_i = 1'b1;
        drain("rdy_drain");
        check("rdy_count_after", 64'(count_o), 64'(0));
        m_tail = 1;

        for (int ep = 0; ep < 40; ep++) episode(ep);

        // Asynchronous reset mid-cycle.
        alloc(KREG, 5'd17);
        push_ev(1'b1, 5'd17, 32'hCAFE, 1'b0, 1'b0, 32'h0);
        complete(1, TAG_W'(m_tail), 32'hCAFE, 1'b0, 32'h0);
        drain("pre_reset_drain");
        alloc(KREG, 5'd18);
        @(posedge clk_i);
        #3 rst_ni = 1'b0;
        #1;
        check("async_reset_a", 64'({cm0_valid_o, cm1_valid_o, cm_store_o, redirect_valid_o,
                                    count_o, full_o, cm0_rd_o, cm0_value_o}), 64'(0));
        check("async_reset_b", 64'({cm1_rd_o, cm1_value_o}), 64'(0));
        check("async_reset_c", 64'({redirect_pc_o, alloc_tag_o}), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
